// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM states, default constants and duty clamp for the pwm_nch slice
package pwm_pkg;
  localparam int PWM_WIDTH      = 11;
  localparam int PWM_NONOVERLAP = 64;
  localparam int PWM_BLANK      = 128;
  typedef enum logic [1:0] {OFF, LOAD, RUN} state_t;
  // keep the duty far enough from both period ends that deadtime always fits
  function automatic int clamp_duty(input int d, input int mx, input int no);
    return d < no ? no : d > mx - no ? mx - no : d;
  endfunction
endpackage

// File: rtl/pwm_nch_if.sv
// pwm_nch_if: duty input and gate/sync/blank outputs of pwm_nch
//   en, duty, duty_vld            : control side -> generator
//   PWM_hi, PWM_lo, duty_clip     : per-channel outputs
//   PWM_synch, ovr_I_blank        : shared outputs
interface pwm_nch_if import pwm_pkg::*; #(
  parameter int WIDTH = PWM_WIDTH,
  parameter int NCH   = 2
);
  logic                 en;
  logic                 duty_vld;
  logic [NCH*WIDTH-1:0] duty;
  logic [NCH-1:0]       PWM_hi;
  logic [NCH-1:0]       PWM_lo;
  logic [NCH-1:0]       duty_clip;
  logic                 PWM_synch;
  logic                 ovr_I_blank;
  modport master (output en, duty_vld, duty, input PWM_hi, PWM_lo, duty_clip, PWM_synch, ovr_I_blank);
  modport slave  (input en, duty_vld, duty, output PWM_hi, PWM_lo, duty_clip, PWM_synch, ovr_I_blank);
endinterface

// File: rtl/pwm_chan.sv
// pwm_chan: one complementary channel with active duty, gate compares and clip pulse
//   i_load   : load clamped shadow into the active duty this cycle
//   i_run    : generator running (RUN and enabled)
//   i_cnt    : shared period counter
//   i_shadow : this channel's shadow duty
//   o_hi/o_lo: registered gates, o_blank: combinational blank window, o_clip: clamp pulse
module pwm_chan import pwm_pkg::*; #(
  parameter int WIDTH      = PWM_WIDTH,
  parameter int NONOVERLAP = PWM_NONOVERLAP,
  parameter int BLANK      = PWM_BLANK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_shadow,
  output logic             o_hi,
  output logic             o_lo,
  output logic             o_blank,
  output logic             o_clip
);
  localparam int MAX = 2**WIDTH - 1;
  localparam logic [WIDTH:0] NO = (WIDTH+1)'(NONOVERLAP);
  localparam logic [WIDTH:0] BL = (WIDTH+1)'(BLANK);
  localparam logic [WIDTH:0] NB = (WIDTH+1)'(NONOVERLAP + BLANK);
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] w_clamped;
  logic [WIDTH:0]   w_c;
  logic [WIDTH:0]   w_d;
  logic [WIDTH:0]   w_dn;
  // one extra bit so duty+deadtime+blank never wraps into the next period
  always_comb begin
    w_clamped = WIDTH'(clamp_duty(int'(i_shadow), MAX, NONOVERLAP));
    w_c       = {1'b0, i_cnt};
    w_d       = {1'b0, r_duty};
    w_dn      = w_d + NO;
    o_blank   = i_run && ((w_c >= NO && w_c < NB) || (w_c >= w_dn && w_c < w_dn + BL));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= WIDTH'(NONOVERLAP);
      o_hi   <= 1'b0;
      o_lo   <= 1'b0;
      o_clip <= 1'b0;
    end else begin
      if (i_load) r_duty <= w_clamped;
      o_clip <= i_load && w_clamped != i_shadow;
      o_hi   <= i_run && w_c >= NO && w_c < w_d;
      o_lo   <= i_run && w_c >= w_dn && i_cnt != '1;
    end
  end
endmodule

// File: rtl/pwm_nch.sv
// pwm_nch: multi-channel complementary PWM with deadtime, double-buffered duty and blanking
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pwm_nch_if slave (en, duty, duty_vld in; gates, sync, blank, clip out)
module pwm_nch import pwm_pkg::*; #(
  parameter int WIDTH      = PWM_WIDTH,
  parameter int NCH        = 2,
  parameter int NONOVERLAP = PWM_NONOVERLAP,
  parameter int BLANK      = PWM_BLANK
) (
  input logic      clk,
  input logic      rst_n,
  pwm_nch_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_cnt;
  logic [NCH*WIDTH-1:0] r_shadow;
  logic                 r_synch;
  logic                 r_blank;
  logic                 w_run;
  logic                 w_load;
  logic [NCH-1:0]       w_hi;
  logic [NCH-1:0]       w_lo;
  logic [NCH-1:0]       w_blank;
  logic [NCH-1:0]       w_clip;
  // dropping en overrides every state so gates fall on the very next edge
  always_comb begin
    w_next = !bus.en ? OFF : r_state == OFF ? LOAD : RUN;
    w_run  = r_state == RUN && bus.en;
    w_load = bus.en && (r_state == LOAD || (r_state == RUN && r_cnt == MAX));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= OFF;
      r_cnt    <= '0;
      r_shadow <= {NCH{WIDTH'(NONOVERLAP)}};
      r_synch  <= 1'b0;
      r_blank  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_run ? r_cnt + WIDTH'(1) : '0;
      if (bus.duty_vld) r_shadow <= bus.duty;
      r_synch <= w_run && r_cnt == '0;
      r_blank <= |w_blank;
    end
  end
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pwm_chan #(.WIDTH(WIDTH), .NONOVERLAP(NONOVERLAP), .BLANK(BLANK)) u_chan (
      .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_run(w_run), .i_cnt(r_cnt),
      .i_shadow(r_shadow[k*WIDTH +: WIDTH]),
      .o_hi(w_hi[k]), .o_lo(w_lo[k]), .o_blank(w_blank[k]), .o_clip(w_clip[k])
    );
  end
  assign bus.PWM_hi      = w_hi;
  assign bus.PWM_lo      = w_lo;
  assign bus.duty_clip   = w_clip;
  assign bus.PWM_synch   = r_synch;
  assign bus.ovr_I_blank = r_blank;
endmodule

// File: tb/tb_pwm_nch.sv
// tb_pwm_nch: directed and randomized checks of pwm_nch against a cycle reference model
module tb_pwm_nch;
  localparam int W = 11, N = 2, NO = 64, BL = 128, MX = 2047;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pwm_nch_if #(.WIDTH(W), .NCH(N)) bus();
  pwm_nch #(.WIDTH(W), .NCH(N), .NONOVERLAP(NO), .BLANK(BL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  bit chk_on = 0;
  logic [7:0] outs, exp_o;
  assign outs = {bus.PWM_hi, bus.PWM_lo, bus.PWM_synch, bus.ovr_I_blank, bus.duty_clip};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  function automatic int clampf(input int d);
    return d < NO ? NO : d > MX - NO ? MX - NO : d;
  endfunction
  int m_st, m_cnt, m_sh[N], m_act[N];
  always @(posedge clk or negedge rst_n) begin : mdl
    bit run, load, bl;
    logic [N-1:0] hi, lo, cl;
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; exp_o = '0;
      for (int k = 0; k < N; k++) begin m_sh[k] = NO; m_act[k] = NO; end
    end else begin
      run  = m_st == 2 && bus.en;
      load = bus.en && (m_st == 1 || (m_st == 2 && m_cnt == MX));
      bl   = 0;
      for (int k = 0; k < N; k++) begin
        hi[k] = run && m_cnt >= NO && m_cnt < m_act[k];
        lo[k] = run && m_cnt >= m_act[k] + NO && m_cnt != MX;
        bl |= run && ((m_cnt >= NO && m_cnt < NO + BL) || (m_cnt >= m_act[k] + NO && m_cnt < m_act[k] + NO + BL));
        cl[k] = load && clampf(m_sh[k]) != m_sh[k];
        if (load) m_act[k] = clampf(m_sh[k]);
        if (bus.duty_vld) m_sh[k] = int'(bus.duty[k*W +: W]);
      end
      exp_o = {hi, lo, run && m_cnt == 0, bl, cl};
      m_cnt = run ? (m_cnt + 1) % (MX + 1) : 0;
      m_st  = !bus.en ? 0 : m_st == 0 ? 1 : 2;
    end
  end
  always @(negedge clk) if (chk_on) chk("cycle", {24'b0, outs}, {24'b0, exp_o});
  int c_hi0, c_lo0, c_hi1, c_lo1, c_bl, c_sy, c_ov, c_cl0;
  task automatic wait_synch();
    int n = 0;
    while (!bus.PWM_synch && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("synch_timeout", 0, 1);
  endtask
  task automatic measure(input int mid_i, input logic [N*W-1:0] mid_duty);
    c_hi0 = 0; c_lo0 = 0; c_hi1 = 0; c_lo1 = 0; c_bl = 0; c_sy = 0; c_ov = 0; c_cl0 = 0;
    wait_synch();
    for (int i = 0; i < 2048; i++) begin
      c_hi0 += int'(bus.PWM_hi[0]);
      c_lo0 += int'(bus.PWM_lo[0]);
      c_hi1 += int'(bus.PWM_hi[1]);
      c_lo1 += int'(bus.PWM_lo[1]);
      c_bl  += int'(bus.ovr_I_blank);
      c_sy  += int'(bus.PWM_synch);
      c_ov  += int'(|(bus.PWM_hi & bus.PWM_lo));
      c_cl0 += int'(bus.duty_clip[0]);
      if (i == mid_i) begin bus.duty = mid_duty; bus.duty_vld = 1'b1; end
      else bus.duty_vld = 1'b0;
      @(negedge clk);
    end
    bus.duty_vld = 1'b0;
  endtask
  function automatic logic [W-1:0] rnd_duty();
    int e[8];
    e = '{0, 63, 64, 65, 1982, 1983, 1984, 2047};
    return ($urandom % 4 == 0) ? W'(e[$urandom % 8]) : W'($urandom % 2048);
  endfunction
  initial begin
    int n;
    bus.en = 1'b0; bus.duty_vld = 1'b0; bus.duty = {11'h200, 11'h400};
    repeat (2) @(negedge clk);
    chk("rst_outs", {24'b0, outs}, 0);
    chk("rst_shadow", 32'(dut.r_shadow), {10'b0, 11'd64, 11'd64});
    rst_n = 1'b1; chk_on = 1;
    @(negedge clk); bus.duty_vld = 1'b1;
    @(negedge clk); bus.duty_vld = 1'b0; bus.en = 1'b1;
    measure(-1, '0);
    chk("nom_hi0", c_hi0, 960);
    chk("nom_lo0", c_lo0, 959);
    chk("nom_hi1", c_hi1, 448);
    chk("nom_lo1", c_lo1, 1471);
    chk("nom_blank", c_bl, 384);
    chk("nom_synch", c_sy, 1);
    chk("nom_overlap", c_ov, 0);
    chk("nom_clip0", c_cl0, 0);
    measure(12'h2FF, {11'h600, 11'h400});
    chk("upd_keep_hi1", c_hi1, 448);
    measure(2046, {11'h100, 11'h400});
    chk("upd_next_hi1", c_hi1, 1472);
    measure(-1, '0);
    chk("maxvld_defer_hi1", c_hi1, 1472);
    measure(-1, '0);
    chk("maxvld_apply_hi1", c_hi1, 192);
    measure(100, {11'h100, 11'h010});
    measure(-1, '0);
    chk("clamp_lo_hi0", c_hi0, 0);
    chk("clamp_lo_lo0", c_lo0, 1919);
    chk("clamp_lo_clip0", c_cl0, 1);
    measure(100, {11'h100, 11'h7F0});
    measure(-1, '0);
    chk("clamp_hi_hi0", c_hi0, 1919);
    chk("clamp_hi_lo0", c_lo0, 0);
    chk("clamp_hi_clip0", c_cl0, 1);
    repeat (300) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    chk("endrop_outs", {24'b0, outs}, 0);
    chk("endrop_cnt", 32'(dut.r_cnt), 0);
    bus.duty = {11'h300, 11'h500}; bus.duty_vld = 1'b1;
    @(negedge clk); bus.duty_vld = 1'b0;
    repeat (3) @(negedge clk);
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    chk("relaunch_synch_early", 32'(bus.PWM_synch), 0);
    @(negedge clk);
    chk("relaunch_synch", 32'(bus.PWM_synch), 1);
    measure(-1, '0);
    chk("relaunch_hi0", c_hi0, 1216);
    chk("relaunch_hi1", c_hi1, 704);
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      bus.duty_vld = ($urandom % 150) == 0;
      if (bus.duty_vld) for (int k = 0; k < N; k++) bus.duty[k*W +: W] = rnd_duty();
      if (bus.en && $urandom % 3000 == 0) bus.en = 1'b0;
      else if (!bus.en && $urandom % 6 == 0) bus.en = 1'b1;
    end
    @(negedge clk);
    bus.en = 1'b1; bus.duty = {11'h200, 11'h400}; bus.duty_vld = 1'b1;
    @(negedge clk); bus.duty_vld = 1'b0;
    n = 0;
    while (!bus.PWM_hi[0] && n < 6000) begin @(negedge clk); n++; end
    chk("reset_hi_seen", 32'(bus.PWM_hi[0]), 1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_outs", {24'b0, outs}, 0);
    chk("async_rst_state", 32'(dut.r_state), 0);
    chk("async_rst_cnt", 32'(dut.r_cnt), 0);
    chk("async_rst_shadow", 32'(dut.r_shadow), {10'b0, 11'd64, 11'd64});
    chk("async_rst_active", 32'(dut.g_ch[0].u_chan.r_duty), 64);
    bus.en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_outs", {24'b0, outs}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
